// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: one outstanding imem request, DEPTH-entry buffer to decode.
// Optional IFETCH_TIMEOUT_EN adds an ack timeout that raises a sticky fetch_err.
module ifetch_unit #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_hold,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       pc_mem_q    [DEPTH];
  logic              push, pop;
  logic              buf_full;
  logic              timeout_hit;
  logic              err_block;
  logic              set_err;

  assign buf_full = (count_q == CNT_W'(DEPTH));
  assign id_valid = (count_q != '0);
  assign id_instr = instr_mem_q[rd_ptr_q];
  assign id_pc    = pc_mem_q[rd_ptr_q];
  assign imem_addr = addr_q;
  // A pop that coincides with a flush is thrown away with the rest of the buffer.
  assign pop = id_valid && id_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    imem_req = 1'b0;
    pc_hold  = 1'b1;
    push     = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && !buf_full && !err_block) begin
          addr_d  = {pc_in[31:2], 2'b00};
          state_d = BUSY;
        end
      end
      BUSY: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (!flush) begin
            push    = 1'b1;
            pc_hold = 1'b0;
          end
          state_d = IDLE;
        end else if (timeout_hit) begin
          set_err = 1'b1;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The request cannot be withdrawn; wait out the ack and discard it.
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= addr_q;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] wait_q;
  logic       fetch_err_q;

  // Counter reads 0 in the first waiting cycle, so TIMEOUT-1 marks the TIMEOUT-th cycle.
  assign timeout_hit = (wait_q == 8'(TIMEOUT - 1));
  assign err_block   = fetch_err_q;
  assign fetch_err   = fetch_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
    end else if ((state_d == BUSY || state_d == DROP) && (state_d != state_q)) begin
      wait_q <= '0;
    end else if (state_q == BUSY || state_q == DROP) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_err_q <= 1'b0;
    end else if (set_err) begin
      fetch_err_q <= 1'b1;
    end
  end
`else
  logic unused_err;

  assign timeout_hit = 1'b0;
  assign err_block   = 1'b0;
  assign fetch_err   = 1'b0;
  assign unused_err  = set_err;
`endif

  logic unused_bits;
  assign unused_bits = ^{pc_in[1:0], TIMEOUT == 0};

endmodule
